// File: rtl/twiddle_seq_if.sv
// Twiddle sequencer bus: shared cosine-ROM read port plus the valid/ready
// twiddle stream towards the butterfly datapath.
interface twiddle_seq_if #(
  parameter int LOG2N = 10,
  parameter int TW_W  = 16
);
  logic                   twact;
  logic [LOG2N-3:0]       twa;
  logic signed [TW_W-1:0] twdr_cos;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [TW_W-1:0] tw_re;
  logic signed [TW_W-1:0] tw_im;
  logic [3:0]             tw_stage;
  logic [LOG2N-2:0]       tw_bfly;

  modport master (
    output twact, twa,
    input  twdr_cos,
    output out_valid,
    input  out_ready,
    output tw_re, tw_im, tw_stage, tw_bfly
  );

  modport slave (
    input  twact, twa,
    output twdr_cos,
    input  out_valid,
    output out_ready,
    input  tw_re, tw_im, tw_stage, tw_bfly
  );
endinterface

// File: rtl/twiddle_seq.sv
// Radix-2 DIT FFT twiddle sequencer: walks stages/butterflies, reads a
// quarter-wave cosine ROM twice per twiddle and folds to W = cos - j*sin.
module twiddle_seq #(
  parameter int LOG2N = 10,
  parameter int TW_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  twiddle_seq_if.master tw
);
  localparam int AW = LOG2N - 2;
  localparam int KW = LOG2N - 1;

  typedef enum logic [2:0] {IDLE, RD_COS, RD_SIN, CAPT, HOLD} state_t;

  state_t                 state, state_d;
  logic [3:0]             s_q, s_d;
  logic [KW-1:0]          k_q, k_d;
  logic                   done_q, done_d;
  logic                   last;
  logic [KW-1:0]          kmask, e;
  logic [AW-1:0]          cos_a, sin_a;
  logic                   cz, sz, cneg;
  logic [AW-1:0]          twa_q;
  logic                   cz_q, sz_q, cneg_q;
  logic signed [TW_W-1:0] cos_cap;
  logic signed [TW_W-1:0] re_q, im_q;
  logic [3:0]             stage_q;
  logic [KW-1:0]          bfly_q;
  logic                   ovalid_q;

  always_comb begin
    state_d = state;
    s_d     = s_q;
    k_d     = k_q;
    done_d  = 1'b0;
    last    = (s_q == 4'(LOG2N - 1)) && (k_q == '1);
    case (state)
      IDLE: begin
        if (start) begin
          s_d     = '0;
          k_d     = '0;
          state_d = RD_COS;
        end
      end
      RD_COS: state_d = RD_SIN;
      RD_SIN: state_d = CAPT;
      CAPT:   state_d = HOLD;
      HOLD: begin
        if (tw.out_ready) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            if (k_q == '1) begin
              k_d = '0;
              s_d = s_q + 4'd1;
            end else begin
              k_d = k_q + 1'b1;
            end
            state_d = RD_COS;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      s_d     = s_q;
      k_d     = k_q;
      done_d  = 1'b0;
    end
  end

  // Fold is evaluated on the next indices so twa is registered in the same
  // cycle the state enters RD_COS / RD_SIN.
  always_comb begin
    kmask = KW'((32'd1 << s_d) - 32'd1);
    e     = (k_d & kmask) << (KW - int'(s_d));
    cos_a = '0;
    sin_a = '0;
    cz    = 1'b0;
    sz    = 1'b0;
    cneg  = 1'b0;
    if (e == '0) begin
      sz = 1'b1;
    end else if (!e[KW-1]) begin
      cos_a = e[AW-1:0];
      sin_a = '0 - e[AW-1:0];
    end else if (e[AW-1:0] == '0) begin
      cz = 1'b1;
    end else begin
      cos_a = '0 - e[AW-1:0];
      cneg  = 1'b1;
      sin_a = e[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      s_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      twa_q    <= '0;
      cz_q     <= 1'b0;
      sz_q     <= 1'b0;
      cneg_q   <= 1'b0;
      cos_cap  <= '0;
      re_q     <= '0;
      im_q     <= '0;
      stage_q  <= '0;
      bfly_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state    <= state_d;
      s_q      <= s_d;
      k_q      <= k_d;
      done_q   <= done_d;
      ovalid_q <= (state_d == HOLD);
      if (state_d == RD_COS) begin
        twa_q  <= cos_a;
        cz_q   <= cz;
        sz_q   <= sz;
        cneg_q <= cneg;
      end
      if (state_d == RD_SIN) twa_q <= sin_a;
      if (state == RD_SIN) cos_cap <= tw.twdr_cos;
      if (state == CAPT && state_d == HOLD) begin
        re_q    <= cz_q ? '0 : (cneg_q ? -cos_cap : cos_cap);
        im_q    <= sz_q ? '0 : -tw.twdr_cos;
        stage_q <= s_q;
        bfly_q  <= k_q;
      end
    end
  end

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign tw.twact     = (state == RD_COS) || (state == RD_SIN);
  assign tw.twa       = twa_q;
  assign tw.out_valid = ovalid_q;
  assign tw.tw_re     = re_q;
  assign tw.tw_im     = im_q;
  assign tw.tw_stage  = stage_q;
  assign tw.tw_bfly   = bfly_q;
endmodule

// File: tb/tb_twiddle_seq.sv
// Directed bench for twiddle_seq with a registered-read cosine ROM model.
module tb_twiddle_seq;
  logic clk = 1'b0;
  logic rst_n, start, abort, busy, done;
  int   errors = 0;
  int   checks = 0;
  logic signed [15:0] rom [256];

  always #5 clk = ~clk;

  twiddle_seq_if #(.LOG2N(10), .TW_W(16)) bus ();

  twiddle_seq #(.LOG2N(10), .TW_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .tw    (bus)
  );

  always @(posedge clk) if (bus.twact) bus.twdr_cos <= rom[bus.twa];

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference twiddle for stage s, butterfly k from the ROM table.
  function automatic void model(input int s, input int k, output int re, output int im);
    int e;
    e = (k % (1 << s)) << (9 - s);
    if (e == 0)        begin re = rom[0];          im = 0;               end
    else if (e < 256)  begin re = rom[e];          im = -rom[256 - e];   end
    else if (e == 256) begin re = 0;               im = -rom[0];         end
    else               begin re = -rom[512 - e];   im = -rom[e - 256];   end
  endfunction

  initial begin
    int hs, cyc, es, ek, mre, mim, twa_prev, twa_last;
    int sre, sim, sst, sbf;
    bit got_done;
    for (int i = 0; i < 256; i++) rom[i] = 16'((i * 97 + 13) & 32'h7fff);
    rom[0] = 16'sd32767; rom[1] = 16'sd32766; rom[128] = 16'sd23169; rom[255] = 16'sd200;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bus.out_ready = 1'b0;
    tick; tick;
    chk("rst_busy", busy, 0);           chk("rst_done", done, 0);
    chk("rst_twact", bus.twact, 0);     chk("rst_twa", bus.twa, 0);
    chk("rst_valid", bus.out_valid, 0); chk("rst_re", bus.tw_re, 0);
    chk("rst_im", bus.tw_im, 0);        chk("rst_stage", bus.tw_stage, 0);
    chk("rst_bfly", bus.tw_bfly, 0);

    rst_n = 1'b1; tick; tick;
    start = 1'b1; tick; start = 1'b0;
    chk("c1_twact", bus.twact, 1); chk("c1_twa", bus.twa, 0); chk("c1_busy", busy, 1);
    tick; chk("c2_twact", bus.twact, 1);
    tick; chk("c3_twact", bus.twact, 0); chk("c3_valid", bus.out_valid, 0);
    tick; chk("c4_valid", bus.out_valid, 1);
    chk("first_re", bus.tw_re, 32767); chk("first_im", bus.tw_im, 0);
    chk("first_stage", bus.tw_stage, 0); chk("first_bfly", bus.tw_bfly, 0);
    sre = bus.tw_re; sim = bus.tw_im; sst = bus.tw_stage; sbf = bus.tw_bfly;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold_valid", bus.out_valid, 1); chk("hold_twact", bus.twact, 0);
      chk("hold_re", bus.tw_re, sre);      chk("hold_im", bus.tw_im, sim);
      chk("hold_stage", bus.tw_stage, sst); chk("hold_bfly", bus.tw_bfly, sbf);
    end
    bus.out_ready = 1'b1; tick;
    chk("rel_valid", bus.out_valid, 0); chk("rel_twact", bus.twact, 1);
    hs = 1; cyc = 0;
    while (hs < 100 && cyc < 1000) begin
      if (bus.out_valid) hs++;
      tick; cyc++;
    end
    chk("hs100_reached", hs, 100);
    abort = 1'b1; sre = bus.tw_re; sim = bus.tw_im;
    tick; abort = 1'b0;
    chk("abort_busy", busy, 0); chk("abort_valid", bus.out_valid, 0);
    chk("abort_twact", bus.twact, 0); chk("abort_re", bus.tw_re, sre);
    chk("abort_im", bus.tw_im, sim);
    for (int i = 0; i < 3; i++) begin
      chk("abort_nodone", done, 0);
      tick;
    end
    abort = 1'b1; start = 1'b1; tick; abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", busy, 0);
    tick; chk("abort_start_busy2", busy, 0);

    // Full run with out_ready high; stray start pulse at cycle 1000.
    start = 1'b1; tick; start = 1'b0;
    hs = 0; cyc = 0; es = 0; ek = 0; got_done = 1'b0; twa_prev = -1; twa_last = -1;
    while (!got_done && cyc < 25000) begin
      if (done) begin
        got_done = 1'b1;
        chk("run_cycles", cyc, 20480); chk("run_hs", hs, 5120); chk("done_busy", busy, 0);
      end else begin
        if (bus.twact) begin twa_prev = twa_last; twa_last = bus.twa; end
        if (bus.out_valid && bus.out_ready) begin
          model(es, ek, mre, mim);
          chk("run_stage", bus.tw_stage, es); chk("run_bfly", bus.tw_bfly, ek);
          chk("run_re", bus.tw_re, mre);      chk("run_im", bus.tw_im, mim);
          if (es == 9) begin
            case (ek)
              1: begin chk("e1_re", bus.tw_re, 32766); chk("e1_im", bus.tw_im, -200);
                       chk("e1_twa_c", twa_prev, 1); chk("e1_twa_s", twa_last, 255); end
              128: begin chk("e128_re", bus.tw_re, 23169); chk("e128_im", bus.tw_im, -23169); end
              256: begin chk("e256_re", bus.tw_re, 0); chk("e256_im", bus.tw_im, -32767);
                         chk("e256_twa_c", twa_prev, 0); chk("e256_twa_s", twa_last, 0); end
              384: begin chk("e384_re", bus.tw_re, -23169); chk("e384_im", bus.tw_im, -23169); end
              511: begin chk("e511_re", bus.tw_re, -32766); chk("e511_im", bus.tw_im, -200);
                         chk("e511_twa_c", twa_prev, 1); chk("e511_twa_s", twa_last, 255); end
              default: ;
            endcase
          end
          hs++;
          if (ek == 511) begin ek = 0; es++; end else ek++;
        end
        start = (cyc == 1000);
        tick; cyc++;
      end
    end
    start = 1'b0;
    if (!got_done) chk("done_timeout", 0, 1);
    tick;
    chk("done_pulse", done, 0); chk("idle_busy", busy, 0);

    // Asynchronous reset while in CAPT.
    bus.out_ready = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    chk("capt_busy", busy, 1); chk("capt_twact", bus.twact, 0);
    rst_n = 1'b0; #2;
    chk("arst_busy", busy, 0);        chk("arst_valid", bus.out_valid, 0);
    chk("arst_re", bus.tw_re, 0);     chk("arst_im", bus.tw_im, 0);
    chk("arst_stage", bus.tw_stage, 0); chk("arst_bfly", bus.tw_bfly, 0);
    chk("arst_twa", bus.twa, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
- Sequencer for the quarter-wave cosine twiddle ROM (256 entries, registered read, 1-cycle latency) in the 1024-point radix-2 DIT FFT.
- On a start pulse it walks every stage and butterfly, and computes each twiddle exponent.
- It issues one cosine-address read and one sine-address read per twiddle to the single shared ROM port, then folds the results into a full-circle twiddle W = cos - j·sin.
- Twiddles are delivered to the butterfly datapath over a valid/ready handshake.

Parameters:
- LOG2N, 10, FFT size exponent (N = 1024). The ROM address width is LOG2N-2 = 8.
- TW_W, 16, twiddle width, signed two's complement, Q1.15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; accepted only in IDLE.
- abort  in  1  synchronous abort; has priority over everything except reset.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last twiddle is accepted.
- twact  out  1  ROM read enable.
- twa  out  LOG2N-2  ROM address.
- twdr_cos  in  TW_W  ROM data; valid the cycle after twact.
- out_valid  out  1  twiddle available.
- out_ready  in  1  consumer accepts the twiddle.
- tw_re  out  TW_W  cos(2πe/N).
- tw_im  out  TW_W  -sin(2πe/N).
- tw_stage  out  4  stage s of the current twiddle.
- tw_bfly  out  LOG2N-1  butterfly index k of the current twiddle.

Behaviour:
- Reset: state=IDLE; s=0; k=0; all outputs 0. This includes twact, twa, out_valid, done, busy, tw_re, tw_im, tw_stage and tw_bfly.
- Exponent: e = (k mod 2^s) << (LOG2N-1-s), 9 bits, range 0..511. The loops are s = 0..LOG2N-1 (outer) and k = 0..N/2-1 (inner), giving 5120 twiddles per run.
- Quadrant folding:
  - e=0: cos address = 0; sin is forced to 0.
  - 1 ≤ e ≤ 255: cos = rom[e]; sin = rom[256-e].
  - e=256: cos is forced to 0; sin = rom[0].
  - 257 ≤ e ≤ 511: cos = -rom[512-e]; sin = rom[e-256].
  - Forced-zero and negate flags are pipelined alongside the ROM reads.
  - For a forced-zero half, twa is still driven (value 0) and twact still pulses; its data is discarded.
  - Negation cannot overflow, because ROM values are ≤ 32767.
- FSM (start accepted in IDLE at cycle c gives out_valid high from cycle c+4):
  - IDLE: if start, load s=0, k=0 and go to RD_COS.
  - RD_COS: twact=1, twa=cos address; go to RD_SIN.
  - RD_SIN: twact=1, twa=sin address; capture twdr_cos (the cos value) and go to CAPT.
  - CAPT: twact=0; register tw_re and tw_im from the captured cos, the current twdr_cos (sin) and the flags; tw_im = -sin. Load tw_stage and tw_bfly, set out_valid=1 and go to HOLD.
  - HOLD: while out_ready=0, hold every output stable and keep twact=0.
  - HOLD with out_ready=1: clear out_valid next cycle.
    - If s=LOG2N-1 and k=N/2-1: pulse done and go to IDLE.
    - Otherwise advance: k+1, or wrap k to 0 and s+1. Go to RD_COS.
- Throughput: 4 cycles per twiddle with out_ready held high; 20480 cycles per run.
- twa holds its last value when twact=0.
- start while busy: ignored.
- abort in any non-IDLE state: next cycle IDLE, out_valid=0, twact=0, no done pulse. tw_re and tw_im keep their values.
- start and abort asserted in the same cycle in IDLE: abort wins and start is ignored.
- rst_n asserted mid-run: all outputs return immediately to their reset values.

Test Plan:
- Reset with out_ready=0 → every output is 0. Pulse start at cycle c → twact high at c+1 and c+2; out_valid rises at c+4 with tw_re=32767, tw_im=0, tw_stage=0, tw_bfly=0.
- Stage 9, k=1 (e=1) → twa sequence 1 then 255; tw_re=32766, tw_im=-200. For k=128 (e=128) → tw_re=23169, tw_im=-23169.
- Stage 9, k=256 → tw_re=0, tw_im=-32767. For k=384 (e=384) → tw_re=-23169, tw_im=-23169. For k=511 (e=511) → twa 1 then 255; tw_re=-32766, tw_im=-200.
- Hold out_ready=0 for 10 cycles during HOLD → tw_re, tw_im, tw_stage and tw_bfly are stable and twact=0 throughout. Raise out_ready → the next RD_COS follows the cycle after.
- Full run with out_ready=1 → exactly 5120 handshakes; done is a single pulse at the cycle after the last handshake; busy goes low with it; total is 20480 cycles. A start pulse mid-run has no effect.
- Assert abort after 100 handshakes → IDLE next cycle, no done pulse. A new start then restarts from s=0, k=0 with tw_re=32767. Asserting rst_n=0 mid-CAPT clears out_valid asynchronously.
